// File: rtl/lsh_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lsh_op_sequencer
//  Description : Sequences insert/query operations onto an LSH input handler.
//                Round-robin arbitration between insert and query requests,
//                a one-cycle handler strobe, a programmable settle wait, and
//                for queries a linear scan of the per-window match counts to
//                find the best (lowest-index on ties) window.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsh_op_sequencer #(
  parameter int NUM_BANDS     = 16,
  parameter int NUM_WINDOWS   = 16,
  parameter int COUNT_W       = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              insValid,
  input  logic [$clog2(NUM_WINDOWS)-1:0]    insWindowID,
  input  logic [NUM_BANDS*8-1:0]            insSketch,
  output logic                              insReady,
  output logic                              insDone,
  input  logic                              qryValid,
  input  logic [NUM_BANDS*8-1:0]            qrySketch,
  output logic                              qryReady,
  output logic                              qryDone,
  output logic [$clog2(NUM_WINDOWS)-1:0]    qryBestWindow,
  output logic [COUNT_W-1:0]                qryBestCount,
  output logic                              isInsert,
  output logic                              isQuery,
  output logic [$clog2(NUM_WINDOWS)-1:0]    windowID,
  output logic [NUM_BANDS*8-1:0]            hashedSketch,
  input  logic [NUM_WINDOWS*COUNT_W-1:0]    countBus,
  output logic                              busy
);

  localparam int c_WID = $clog2(NUM_WINDOWS);
  localparam int c_SK  = NUM_BANDS * 8;
  localparam int c_SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [c_SW-1:0]  c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
  localparam logic [c_WID-1:0] c_IDX_LAST    = c_WID'(NUM_WINDOWS - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ISSUE  = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_SCAN   = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  logic [2:0]         r_state;
  logic               r_is_query;
  logic               r_last_query;
  logic [c_SW-1:0]    r_settle_cnt;
  logic [c_WID-1:0]   r_scan_idx;
  logic [c_WID-1:0]   r_best_idx;
  logic [COUNT_W-1:0] r_best_cnt;
  logic [c_WID-1:0]   r_out_win;
  logic [COUNT_W-1:0] r_out_cnt;
  logic [c_SK-1:0]    r_sketch;
  logic [c_WID-1:0]   r_window;

  logic               w_idle;
  logic               w_grant_ins;
  logic               w_grant_qry;
  logic [COUNT_W-1:0] w_counts [NUM_WINDOWS];
  logic [COUNT_W-1:0] w_cur_cnt;
  logic               w_better;

  // Split the flat count bus into one entry per window.
  for (genvar g = 0; g < NUM_WINDOWS; g++) begin : g_unpack
    assign w_counts[g] = countBus[COUNT_W*g +: COUNT_W];
  end

  // Round-robin arbitration and the live count compare used during the scan.
  always_comb begin
    w_idle      = (r_state == c_IDLE);
    w_grant_ins = insValid & (~qryValid | r_last_query);
    w_grant_qry = qryValid & (~insValid | ~r_last_query);
    w_cur_cnt   = w_counts[r_scan_idx];
    w_better    = (w_cur_cnt > r_best_cnt);
  end

  assign insReady      = w_idle & w_grant_ins;
  assign qryReady      = w_idle & w_grant_qry;
  assign isInsert      = (r_state == c_ISSUE) & ~r_is_query;
  assign isQuery       = (r_state == c_ISSUE) &  r_is_query;
  assign insDone       = (r_state == c_DONE)  & ~r_is_query;
  assign qryDone       = (r_state == c_DONE)  &  r_is_query;
  assign busy          = ~w_idle;
  assign windowID      = r_window;
  assign hashedSketch  = r_sketch;
  assign qryBestWindow = r_out_win;
  assign qryBestCount  = r_out_cnt;

  // Operation FSM: accept, strobe handler, settle, optional scan, complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_is_query   <= 1'b0;
      r_last_query <= 1'b1;   // insert wins the first contested grant
      r_settle_cnt <= '0;
      r_scan_idx   <= '0;
      r_best_idx   <= '0;
      r_best_cnt   <= '0;
      r_out_win    <= '0;
      r_out_cnt    <= '0;
      r_sketch     <= '0;
      r_window     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (insReady) begin
            r_sketch     <= insSketch;
            r_window     <= insWindowID;
            r_is_query   <= 1'b0;
            r_last_query <= 1'b0;
            r_state      <= c_ISSUE;
          end else if (qryReady) begin
            r_sketch     <= qrySketch;
            r_window     <= '0;
            r_is_query   <= 1'b1;
            r_last_query <= 1'b1;
            r_best_idx   <= '0;
            r_best_cnt   <= '0;
            r_state      <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_settle_cnt <= '0;
          r_state      <= c_SETTLE;
        end
        c_SETTLE: begin
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_scan_idx <= '0;
            r_state    <= r_is_query ? c_SCAN : c_DONE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        c_SCAN: begin
          if (w_better) begin
            r_best_idx <= r_scan_idx;
            r_best_cnt <= w_cur_cnt;
          end
          if (r_scan_idx == c_IDX_LAST) begin
            // Fold in the final entry so results are valid alongside qryDone.
            r_out_win <= w_better ? r_scan_idx : r_best_idx;
            r_out_cnt <= w_better ? w_cur_cnt  : r_best_cnt;
            r_state   <= c_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsh_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsh_op_sequencer
//  Description : Directed self-checking bench for lsh_op_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsh_op_sequencer;

  logic         clk;
  logic         reset;
  logic         insValid;
  logic [3:0]   insWindowID;
  logic [127:0] insSketch;
  logic         insReady;
  logic         insDone;
  logic         qryValid;
  logic [127:0] qrySketch;
  logic         qryReady;
  logic         qryDone;
  logic [3:0]   qryBestWindow;
  logic [4:0]   qryBestCount;
  logic         isInsert;
  logic         isQuery;
  logic [3:0]   windowID;
  logic [127:0] hashedSketch;
  logic [79:0]  countBus;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  lsh_op_sequencer #(
    .NUM_BANDS(16), .NUM_WINDOWS(16), .COUNT_W(5), .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset),
    .insValid(insValid), .insWindowID(insWindowID), .insSketch(insSketch),
    .insReady(insReady), .insDone(insDone),
    .qryValid(qryValid), .qrySketch(qrySketch), .qryReady(qryReady),
    .qryDone(qryDone), .qryBestWindow(qryBestWindow), .qryBestCount(qryBestCount),
    .isInsert(isInsert), .isQuery(isQuery), .windowID(windowID),
    .hashedSketch(hashedSketch), .countBus(countBus), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_counts(input int v);
    for (int w = 0; w < 16; w++) countBus[5*w +: 5] = v[4:0];
  endtask

  task automatic set_count(input int w, input int v);
    countBus[5*w +: 5] = v[4:0];
  endtask

  // Insert: accept at edge 0, then observe cycles 1..8 after it.
  task automatic run_insert(input logic [3:0] id, input logic [127:0] sk, input bit toggle,
                            output int done_cyc, output int done_pulses, output int strobes);
    insWindowID = id; insSketch = sk; insValid = 1'b1;
    #1;
    check("ins_ready_accept", insReady, 1'b1);
    tick();
    insValid = 1'b0;
    done_cyc = -1; done_pulses = 0; strobes = 0;
    for (int c = 1; c <= 8; c++) begin
      if (isInsert) strobes++;
      if (insDone) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 1) begin
        check("ins_windowID", windowID, id);
        check("ins_sketch_lo", hashedSketch[63:0], sk[63:0]);
      end
      if (toggle && c == 2) begin
        insValid = 1'b1;
        #1;
        check("ins_ready_settle", insReady, 1'b0);
      end
      if (toggle && c == 3) insValid = 1'b0;
      tick();
    end
  endtask

  // Query: accept at edge 0, then observe cycles 1..30 after it.
  task automatic run_query(input logic [127:0] sk, output int done_cyc, output int done_pulses);
    qrySketch = sk; qryValid = 1'b1;
    #1;
    check("qry_ready_accept", qryReady, 1'b1);
    tick();
    qryValid = 1'b0;
    done_cyc = -1; done_pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) begin
        check("qry_isQuery_c1", isQuery, 1'b1);
        check("qry_windowID_zero", windowID, 4'd0);
        check("qry_sketch_hi", hashedSketch[127:64], sk[127:64]);
      end
      if (qryDone) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      tick();
    end
  endtask

  int dc, dp, st;
  int grants [3];
  int ngr, both_hi, extra_done;

  initial begin
    reset = 1'b1; insValid = 1'b0; qryValid = 1'b0;
    insWindowID = '0; insSketch = '0; qrySketch = '0; countBus = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_isInsert", isInsert, 1'b0);
    check("rst_sketch", hashedSketch[63:0], 64'd0);
    check("rst_best", {qryBestWindow, qryBestCount}, 9'd0);
    reset = 1'b0;
    tick();

    // Basic insert, window 14.
    run_insert(4'd14, {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98}, 1'b0, dc, dp, st);
    check("ins_done_cycle", dc, 3);
    check("ins_done_pulses", dp, 1);
    check("ins_strobes", st, 1);
    insValid = 1'b1; #1;
    check("ins_ready_again", insReady, 1'b1);
    insValid = 1'b0;

    // Query: window 14 = 9, others 2.
    set_all_counts(2); set_count(14, 9);
    run_query({64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, dc, dp);
    check("qry_done_cycle", dc, 19);
    check("qry_done_pulses", dp, 1);
    check("qry_best_win", qryBestWindow, 4'd14);
    check("qry_best_cnt", qryBestCount, 5'd9);
    set_all_counts(0);
    tick(); tick();
    check("qry_hold_win", qryBestWindow, 4'd14);

    // Tie: 7 at windows 3 and 11.
    set_count(3, 7); set_count(11, 7);
    run_query(128'h0, dc, dp);
    check("tie_best_win", qryBestWindow, 4'd3);
    check("tie_best_cnt", qryBestCount, 5'd7);

    // Top entry alone is highest.
    set_all_counts(1); set_count(15, 31);
    run_query(128'h5, dc, dp);
    check("last_best_win", qryBestWindow, 4'd15);
    check("last_best_cnt", qryBestCount, 5'd31);

    // All zero.
    set_all_counts(0);
    run_query(128'h1, dc, dp);
    check("zero_best", {qryBestWindow, qryBestCount}, 9'd0);

    // Insert toggled during settle.
    run_insert(4'd5, 128'hABC, 1'b1, dc, dp, st);
    check("tog_strobes", st, 1);
    check("tog_done_pulses", dp, 1);

    // Contention after reset: insert, query, insert.
    reset = 1'b1; tick(); reset = 1'b0;
    set_all_counts(3);
    insValid = 1'b1; qryValid = 1'b1; insWindowID = 4'd7;
    ngr = 0; both_hi = 0;
    for (int c = 0; c < 80 && ngr < 3; c++) begin
      tick();
      if (isInsert && isQuery) both_hi++;
      if (isInsert) begin grants[ngr] = 0; ngr++; end
      else if (isQuery) begin grants[ngr] = 1; ngr++; end
    end
    insValid = 1'b0; qryValid = 1'b0;
    check("rr_ngrants", ngr, 3);
    check("rr_g0_ins", grants[0], 0);
    check("rr_g1_qry", grants[1], 1);
    check("rr_g2_ins", grants[2], 0);
    check("rr_no_overlap", both_hi, 0);
    for (int c = 0; c < 30 && busy; c++) tick();
    check("rr_idle_after", busy, 1'b0);

    // Reset mid-scan.
    set_all_counts(2); set_count(14, 9);
    run_query(128'h77, dc, dp);
    check("pre_rst_win", qryBestWindow, 4'd14);
    qryValid = 1'b1; tick(); qryValid = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_outs", {qryDone, isQuery, qryBestWindow, qryBestCount, windowID}, 16'd0);
    check("mid_rst_sketch", hashedSketch[63:0], 64'd0);
    tick(); tick();
    reset = 1'b0;
    extra_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (qryDone) extra_done++;
      tick();
    end
    check("mid_rst_no_done", extra_done, 0);
    run_query(128'h99, dc, dp);
    check("post_rst_done_cycle", dc, 19);
    check("post_rst_best", {qryBestWindow, qryBestCount}, {4'd14, 5'd9});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
